reg_file_sb: RTL



---
 rtl/reg_file_sb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb -- parametrised multi-read-port register file with busy scoreboard.
//
// Purpose:
//   MIPS datapath register file sitting between decode (read/issue) and
//   writeback (write). Reads are registered with a write-first bypass. A
//   per-register busy bit lets decode detect RAW hazards. After every reset
//   the array is swept to zero, one entry per cycle, before 'ready' rises.
//
// Parameters:
//   DATA_W  width of each register
//   ADDR_W  register address width (DEPTH = 2**ADDR_W)
//   NUM_RD  number of read ports (1..4)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   rd_addr     packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   rd_data     packed registered read data, port i = [i*DATA_W +: DATA_W]
//   rd_busy     registered busy flag of each read address
//   wr_en       writeback write enable
//   wr_addr     writeback register
//   wr_data     writeback data
//   issue_en    mark issue_addr busy
//   issue_addr  destination register being issued
//   ready       high once the clear sweep has completed
//
// Optional feature (macro RF_WRITE_TRACE_EN): when defined, every accepted
// write and the end of the clear sweep are printed. State and timing are
// unaffected by the macro.

module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_addr,
    output logic                       ready
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]               state_q, state_d;
    logic [ADDR_W-1:0]        cnt_q, cnt_d;
    logic                     ready_q, ready_d;
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

    // Array storage is never reset; the INIT sweep zeroes it instead.
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_waddr;
    logic [DATA_W-1:0]        mem_wdata;

    logic [ADDR_W-1:0]        ra;
    logic                     hit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        rd_data_d = '0;
        rd_busy_d = '0;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        ra        = '0;
        hit       = 1'b0;

        if (state_q == ST_INIT) begin
            // Sweep: the write port belongs to the counter; writeback and
            // issue are ignored and the read outputs stay zero.
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        end else begin
            mem_we = wr_en && (wr_addr != '0);

            // Clear first, then set: a same-cycle issue to the register being
            // written is the newer producer and must stay busy.
            if (wr_en) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (issue_en && (issue_addr != '0)) begin
                busy_d[issue_addr] = 1'b1;
            end
            busy_d[0] = 1'b0;

            for (int i = 0; i < NUM_RD; i++) begin
                ra  = rd_addr[i*ADDR_W +: ADDR_W];
                hit = wr_en && (wr_addr == ra);
                if (ra != '0) begin
                    // Write-first bypass: the landing write both supplies the
                    // data and retires the pending producer.
                    rd_data_d[i*DATA_W +: DATA_W] = hit ? wr_data : mem_q[ra];
                    rd_busy_d[i]                  = busy_q[ra] && !hit;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_busy = rd_busy_q;
    assign ready   = ready_q;

`ifdef RF_WRITE_TRACE_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if ((state_q == ST_RUN) && wr_en && (wr_addr != '0)) begin
                $display("RF W t=%0t r=%0d d=%0h", $time, wr_addr, wr_data);
            end
            if ((state_q == ST_INIT) && (state_d == ST_RUN)) begin
                $display("RF READY");
            end
        end
    end
`else
    // Trace disabled: no simulation output.
`endif

endmodule
